// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous double-buffered digit load.
// Define SEG_LZB_EN to enable leading-zero blanking; the default build drives every digit.
module seg_scan_ctrl #(
   parameter int DIGITS = 4,
   parameter int DIV    = 50000,
   parameter int BLANK  = 500
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_load_valid,
   output logic                  o_load_ready,
   input  logic [4*DIGITS-1:0]   i_load_data,
   output logic [3:0]            o_bcd,
   input  logic [6:0]            i_seg_in,
   output logic [6:0]            o_seg,
   output logic [DIGITS-1:0]     o_an,
   output logic                  o_frame_done
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);

   typedef enum logic {S_BLANK, S_DRIVE} state_t;
   localparam state_t S_SLOT_START = (BLANK > 0) ? S_BLANK : S_DRIVE;

   function automatic logic [3:0] digit_of(input logic [4*DIGITS-1:0] vec,
                                           input logic [IDX_W-1:0]    idx);
      digit_of = vec[4*int'(idx) +: 4];
   endfunction

   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_idx;
   state_t              r_state;
   logic [4*DIGITS-1:0] r_active;
   logic [4*DIGITS-1:0] r_pending;
   logic                r_pend_valid;
   logic [3:0]          r_bcd;
   logic [DIGITS-1:0]   r_an;
   logic [6:0]          r_seg;
   logic                r_frame_done;

   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [IDX_W-1:0]    w_idx_nxt;
   state_t              w_state_nxt;
   logic                w_wrap;
   logic                w_boundary;
   logic                w_accept;
   logic [4*DIGITS-1:0] w_active_nxt;
   logic [DIGITS-1:0]   w_lit;
   logic                w_drive;
   logic [DIGITS-1:0]   w_an_nxt;
   logic [6:0]          w_seg_nxt;

   // Slot FSM state register: cnt/idx position plus BLANK/DRIVE phase
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_state <= S_SLOT_START;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_cnt_nxt  = r_cnt + 1'b1;
      w_idx_nxt  = r_idx;
      w_wrap     = (r_cnt == CNT_MAX);
      w_boundary = w_wrap && (r_idx == IDX_MAX);
      if (w_wrap) begin
         w_cnt_nxt = '0;
         w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end
      w_state_nxt = (w_cnt_nxt < CNT_BLANK) ? S_BLANK : S_DRIVE;
   end

   assign o_load_ready = !r_pend_valid && !i_reset;
   assign w_accept     = i_load_valid && o_load_ready;
   assign w_active_nxt = (w_boundary && r_pend_valid) ? r_pending : r_active;

`ifdef SEG_LZB_EN
   // A digit stays lit once it or any more-significant digit is non-zero
   always_comb begin : lzb_scan
      logic nz;
      nz    = 1'b0;
      w_lit = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nz       = nz | (r_active[4*i +: 4] != 4'd0);
         w_lit[i] = nz || (i == 0);
      end
   end
`else
   assign w_lit = '1;
`endif

   always_comb begin
      w_drive  = (r_state == S_DRIVE) && w_lit[r_idx];
      w_an_nxt = '0;
      w_seg_nxt = '0;
      if (w_drive) begin
         w_an_nxt  = DIGITS'(1) << r_idx;
         w_seg_nxt = i_seg_in;
      end
   end

   // Buffers and registered outputs; bcd follows the idx that takes effect on this edge
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_active     <= '0;
         r_pending    <= '0;
         r_pend_valid <= 1'b0;
         r_bcd        <= '0;
         r_an         <= '0;
         r_seg        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_active <= w_active_nxt;
         if (w_accept) begin
            r_pending    <= i_load_data;
            r_pend_valid <= 1'b1;
         end else if (w_boundary) begin
            r_pend_valid <= 1'b0;
         end
         r_bcd        <= digit_of(w_active_nxt, w_idx_nxt);
         r_an         <= w_an_nxt;
         r_seg        <= w_seg_nxt;
         r_frame_done <= w_boundary;
      end
   end

   assign o_bcd        = r_bcd;
   assign o_an         = r_an;
   assign o_seg        = r_seg;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (DIGITS=4, DIV=8, BLANK=2): per-cycle vector tables plus a mid-slot reset sequence.
module tb_seg_scan_ctrl;

   localparam int DIGITS = 4;
   localparam int DIV    = 8;
   localparam int BLANK  = 2;
`ifdef SEG_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        lv;
   logic [15:0] ld;
   logic        rdy;
   logic [3:0]  bcd;
   logic [6:0]  seg_in;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        fd;

   int cyc;
   int n_chk;
   int n_pass;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_load_valid (lv),
      .o_load_ready (rdy),
      .i_load_data  (ld),
      .o_bcd        (bcd),
      .i_seg_in     (seg_in),
      .o_seg        (seg),
      .o_an         (an),
      .o_frame_done (fd)
   );

   // External shared decoder, segments gfedcba active-high
   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0: dec7 = 7'h3F;
         4'd1: dec7 = 7'h06;
         4'd2: dec7 = 7'h5B;
         4'd3: dec7 = 7'h4F;
         4'd4: dec7 = 7'h66;
         4'd5: dec7 = 7'h6D;
         4'd6: dec7 = 7'h7D;
         4'd7: dec7 = 7'h07;
         4'd8: dec7 = 7'h7F;
         4'd9: dec7 = 7'h6F;
         default: dec7 = 7'h00;
      endcase
   endfunction

   assign seg_in = dec7(bcd);

   typedef struct {
      logic        first;
      int          cyc;
      logic        lv;
      logic [15:0] ld;
      logic        rdy;
      logic [3:0]  an;
      logic [3:0]  bcd;
      logic        fd;
      logic [3:0]  sd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic first, input int c, input logic v, input logic [15:0] d,
                               input logic r, input logic [3:0] a, input logic [3:0] b,
                               input logic f, input logic [3:0] s);
      vec_t t;
      t.first = first; t.cyc = c; t.lv = v; t.ld = d;
      t.rdy = r; t.an = a; t.bcd = b; t.fd = f; t.sd = s;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      lv    = 1'b0;
      ld    = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic advance_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
         lv = 1'b0;
         cyc++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk  = 0;
      n_pass = 0;
      cyc    = 0;
      reset  = 1'b1;
      lv     = 1'b0;
      ld     = '0;

      //           first cyc lv  data      rdy an    bcd   fd sd
      // Idle scan after reset
      tbl.push_back(mk(1,  0, 0, 16'h0000, 1, 4'h0, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0,  2, 0, 16'h0000, 1, 4'h0, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0,  3, 0, 16'h0000, 1, 4'h1, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0,  8, 0, 16'h0000, 1, 4'h1, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0,  9, 0, 16'h0000, 1, 4'h0, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 11, 0, 16'h0000, 1, 4'h2, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 19, 0, 16'h0000, 1, 4'h4, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 27, 0, 16'h0000, 1, 4'h8, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 32, 0, 16'h0000, 1, 4'h8, 4'h0, 1, 4'h0));
      tbl.push_back(mk(0, 33, 0, 16'h0000, 1, 4'h0, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 64, 0, 16'h0000, 1, 4'h8, 4'h0, 1, 4'h0));
      // Load 0x4321 at cycle 5
      tbl.push_back(mk(1,  5, 1, 16'h4321, 1, 4'h1, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0,  6, 0, 16'h0000, 0, 4'h1, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 31, 0, 16'h0000, 0, 4'h8, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 32, 0, 16'h0000, 1, 4'h8, 4'h1, 1, 4'h0));
      tbl.push_back(mk(0, 34, 0, 16'h0000, 1, 4'h0, 4'h1, 0, 4'h0));
      tbl.push_back(mk(0, 35, 0, 16'h0000, 1, 4'h1, 4'h1, 0, 4'h1));
      tbl.push_back(mk(0, 40, 0, 16'h0000, 1, 4'h1, 4'h2, 0, 4'h1));
      tbl.push_back(mk(0, 43, 0, 16'h0000, 1, 4'h2, 4'h2, 0, 4'h2));
      tbl.push_back(mk(0, 51, 0, 16'h0000, 1, 4'h4, 4'h3, 0, 4'h3));
      tbl.push_back(mk(0, 59, 0, 16'h0000, 1, 4'h8, 4'h4, 0, 4'h4));
      tbl.push_back(mk(0, 64, 0, 16'h0000, 1, 4'h8, 4'h1, 1, 4'h4));
      // 0x1111 accepted, 0x2222 refused while pending
      tbl.push_back(mk(1,  5, 1, 16'h1111, 1, 4'h1, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0,  6, 1, 16'h2222, 0, 4'h1, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0,  7, 0, 16'h0000, 0, 4'h1, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 32, 0, 16'h0000, 1, 4'h8, 4'h1, 1, 4'h0));
      tbl.push_back(mk(0, 43, 0, 16'h0000, 1, 4'h2, 4'h1, 0, 4'h1));
      tbl.push_back(mk(0, 64, 0, 16'h0000, 1, 4'h8, 4'h1, 1, 4'h1));
      tbl.push_back(mk(0, 67, 0, 16'h0000, 1, 4'h1, 4'h1, 0, 4'h1));
      // 0x9999 offered on the boundary cycle itself
      tbl.push_back(mk(1, 31, 1, 16'h9999, 1, 4'h8, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 32, 0, 16'h0000, 0, 4'h8, 4'h0, 1, 4'h0));
      tbl.push_back(mk(0, 35, 0, 16'h0000, 0, 4'h1, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 63, 0, 16'h0000, 0, 4'h8, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 64, 0, 16'h0000, 1, 4'h8, 4'h9, 1, 4'h0));
      tbl.push_back(mk(0, 67, 0, 16'h0000, 1, 4'h1, 4'h9, 0, 4'h9));
      tbl.push_back(mk(0, 75, 0, 16'h0000, 1, 4'h2, 4'h9, 0, 4'h9));
      // 0x0050 then 0x0000: leading zeros dark only with blanking enabled
      tbl.push_back(mk(1,  5, 1, 16'h0050, 1, 4'h1, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 32, 0, 16'h0000, 1, 4'h8, 4'h0, 1, 4'h0));
      tbl.push_back(mk(0, 35, 0, 16'h0000, 1, 4'h1, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 40, 1, 16'h0000, 1, 4'h1, 4'h5, 0, 4'h0));
      tbl.push_back(mk(0, 43, 0, 16'h0000, 0, 4'h2, 4'h5, 0, 4'h5));
      tbl.push_back(mk(0, 51, 0, 16'h0000, 0, LZB ? 4'h0 : 4'h4, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 59, 0, 16'h0000, 0, LZB ? 4'h0 : 4'h8, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 64, 0, 16'h0000, 1, LZB ? 4'h0 : 4'h8, 4'h0, 1, 4'h0));
      tbl.push_back(mk(0, 67, 0, 16'h0000, 1, 4'h1, 4'h0, 0, 4'h0));
      tbl.push_back(mk(0, 75, 0, 16'h0000, 1, LZB ? 4'h0 : 4'h2, 4'h0, 0, 4'h0));

      foreach (tbl[i]) begin
         if (tbl[i].first) do_reset();
         advance_to(tbl[i].cyc);
         lv = tbl[i].lv;
         ld = tbl[i].ld;
         #1;
         chk($sformatf("v%0d.load_ready", i), 32'(rdy), 32'(tbl[i].rdy));
         chk($sformatf("v%0d.an", i),         32'(an),  32'(tbl[i].an));
         chk($sformatf("v%0d.bcd", i),        32'(bcd), 32'(tbl[i].bcd));
         chk($sformatf("v%0d.frame_done", i), 32'(fd),  32'(tbl[i].fd));
         chk($sformatf("v%0d.seg", i),        32'(seg),
             32'((tbl[i].an != 4'h0) ? dec7(tbl[i].sd) : 7'h00));
      end

      // Reset in the middle of slot 2 with 0x7777 pending
      do_reset();
      advance_to(5);
      lv = 1'b1;
      ld = 16'h7777;
      #1;
      chk("rst.accept_ready", 32'(rdy), 32'd1);
      advance_to(20);
      #1;
      chk("rst.pre_an", 32'(an), 32'h4);
      chk("rst.pre_ready", 32'(rdy), 32'd0);
      reset = 1'b1;
      #1;
      chk("rst.ready_in_reset", 32'(rdy), 32'd0);
      @(posedge clk);
      #1;
      chk("rst.an", 32'(an), 32'h0);
      chk("rst.bcd", 32'(bcd), 32'h0);
      chk("rst.seg", 32'(seg), 32'h0);
      chk("rst.frame_done", 32'(fd), 32'h0);
      reset = 1'b0;
      cyc   = 0;
      #1;
      chk("rst.ready_after", 32'(rdy), 32'd1);
      for (int k = 0; k < 70; k++) begin
         advance_to(k);
         if (k > 0) #1;
         chk($sformatf("rst.bcd_c%0d", k), 32'(bcd), 32'h0);
         if (k == 2)  chk("rst.an_c2", 32'(an), 32'h0);
         if (k == 3)  chk("rst.an_c3", 32'(an), 32'h1);
         if (k == 11) chk("rst.an_c11", 32'(an), 32'h2);
         if (k == 32) chk("rst.fd_c32", 32'(fd), 32'd1);
         if (k == 35) chk("rst.seg_c35", 32'(seg), 32'(dec7(4'd0)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
